pic_cmd_sequencer: RTL and testbench
====================================

Name: pic_cmd_sequencer

Overview:
- Bus-side command sequencer for the 8259-style PIC.
- Decodes CPU write cycles (A0, data) into ICW1–ICW4 and OCW1–OCW3, following the initialization order ICW1 → ICW2 → [ICW3] → [ICW4].
- Holds the resulting command registers and drives them straight into the PIC control logic.
- Reports initialization completion and strobes the action commands.

Parameters:
- OCW3_INIT, 8'b00001010, OCW3 value loaded at reset and on every ICW1 (RR=1, RIS=0: read IRR).
- ICW4_DEFAULT, 8'h00, ICW4 value forced when ICW1.IC4=0.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- WR  in  1  write strobe; each high cycle is one write.
- A0  in  1  address bit 0.
- D_IN  in  8  write data.
- ICW1, ICW2, ICW3, ICW4  out  8 each  initialization command registers.
- OCW1  out  8  interrupt mask (IMR).
- OCW2  out  8  last OCW2 written.
- OCW3  out  8  read-select / special-mask register.
- OCW2_STB  out  1  one-cycle pulse the cycle after an OCW2 write.
- INIT_DONE  out  1  high when in READY.
- WR_IGNORED  out  1  one-cycle pulse the cycle after a discarded write.
- INIT_STATE  out  3  current state encoding, for debug.

Behaviour:
- Reset (RST=1 at an edge, wins over WR): all ICW, OCW1 and OCW2 = 0; OCW3 = OCW3_INIT; strobes = 0; INIT_DONE = 0; state UNINIT.
- Decode:
  - ICW1 = A0=0 & D4=1, accepted in any state.
  - A0=1 = next ICW during init, OCW1 in READY.
  - A0=0 & D4=0 & D3=0 = OCW2.
  - A0=0 & D4=0 & D3=1 = OCW3.
- States: UNINIT=0, WAIT_ICW2=1, WAIT_ICW3=2, WAIT_ICW4=3, READY=4.
- ICW1 write, any state: ICW1 <= D_IN; ICW2/ICW3/ICW4 <= 0; OCW1 <= 0; OCW3 <= OCW3_INIT; INIT_DONE <= 0; state <= WAIT_ICW2. Re-init mid-sequence restarts cleanly.
- WAIT_ICW2, A0=1: ICW2 <= D_IN, stored verbatim. Next state:
  - WAIT_ICW3 if ICW1.SNGL(bit1)=0;
  - else WAIT_ICW4 if ICW1.IC4(bit0)=1;
  - else READY, with ICW4 <= ICW4_DEFAULT.
- WAIT_ICW3, A0=1: ICW3 <= D_IN. Next state is WAIT_ICW4 if IC4=1, else READY with ICW4 <= ICW4_DEFAULT.
- WAIT_ICW4, A0=1: ICW4 <= D_IN; state <= READY.
- READY, A0=1: OCW1 <= D_IN.
- READY, OCW2 decode: OCW2 <= D_IN; OCW2_STB=1 for exactly the next cycle.
- READY, OCW3 decode: OCW3 <= D_IN (see Optional Feature).
- Discarded writes; each raises WR_IGNORED for one cycle with no register change:
  - any non-ICW1 write in UNINIT;
  - A0=0 non-ICW1 writes in WAIT_ICW2/3/4.
- Latency: registers and state update on the edge where WR is sampled high and are visible the following cycle. INIT_DONE rises in the cycle after the final required ICW.
- Back-to-back WR on consecutive cycles is legal; each is decoded against the state at that edge.
- WR=0: everything holds; strobes return to 0.

Optional Feature:
- Macro PIC_OCW3_RR_HOLD_EN.
- Defined: an OCW3 write with RR (bit1)=0 leaves OCW3[1:0] unchanged and writes OCW3[7:2] from D_IN. Likewise, ESMM (bit6)=0 leaves OCW3[5] (SMM) unchanged. This is true 8259 semantics.
- Undefined: OCW3 <= D_IN verbatim.

Decomposition:
- Package pic_pkg holds:
  - state encoding constants (UNINIT..READY);
  - bit-index constants: IC4=0, SNGL=1, LTIM=3, ICW1_FLAG=4, OCW3_FLAG=3, RR=1, RIS=0, SMM=5, ESMM=6;
  - default OCW3 value.
- One natural combinational sub-module, pic_cmd_decode: maps (A0, D_IN, state) to one-hot write class {ICW1, ICWn, OCW1, OCW2, OCW3, IGNORE}. The sequencer holds all flops.

Test Plan:
- Reset: RST=1 for 2 cycles with WR=1, A0=0, D_IN=0x1A → all ICW/OCW1/OCW2=0x00, OCW3=0x0A, INIT_DONE=0, INIT_STATE=0.
- Single mode, no ICW4: writes (A0=0, 0x1A) then (A0=1, 0xA8) → ICW1=0x1A, ICW2=0xA8, ICW4=0x00, INIT_DONE=1 one cycle after the 2nd write.
- Cascade with ICW4: writes 0x11, 0xA8, 0x04, 0x02 → INIT_STATE steps 1,2,3,4; ICW3=0x04; ICW4=0x02; INIT_DONE rises only after the 4th write.
- Operational: in READY, writes (A0=1, 0x07), (A0=0, 0x20), (A0=0, 0x08) →
  - OCW1=0x07;
  - OCW2=0x20 with OCW2_STB high for exactly one cycle;
  - OCW3=0x0A with PIC_OCW3_RR_HOLD_EN, 0x08 without.
- Re-init mid-sequence: after ICW1=0x11 and ICW2, write ICW1=0x1B → INIT_STATE=1, OCW1=0x00, ICW2=0x00. Then (A0=1, 0x48) → state 3; then (A0=1, 0x03) → READY, ICW4=0x03.
- Ignored writes: from reset, (A0=1, 0xFF) → WR_IGNORED pulse, OCW1 stays 0x00. In WAIT_ICW2, (A0=0, 0x20) → WR_IGNORED pulse, OCW2 unchanged, state unchanged.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared constants and types for the 8259-style PIC bus-side command sequencer.
package pic_pkg;

    localparam logic [2:0] ST_UNINIT    = 3'd0;
    localparam logic [2:0] ST_WAIT_ICW2 = 3'd1;
    localparam logic [2:0] ST_WAIT_ICW3 = 3'd2;
    localparam logic [2:0] ST_WAIT_ICW4 = 3'd3;
    localparam logic [2:0] ST_READY     = 3'd4;

    localparam int IC4       = 0;
    localparam int SNGL      = 1;
    localparam int LTIM      = 3;
    localparam int ICW1_FLAG = 4;
    localparam int OCW3_FLAG = 3;
    localparam int RR        = 1;
    localparam int RIS       = 0;
    localparam int SMM       = 5;
    localparam int ESMM      = 6;

    localparam logic [7:0] OCW3_INIT_DEF = 8'b0000_1010;

    // Exactly one field is set for every decoded write.
    typedef struct packed {
        logic icw1;
        logic icwn;
        logic ocw1;
        logic ocw2;
        logic ocw3;
        logic ignore;
    } wr_class_t;

endpackage

// File: rtl/pic_cmd_decode.sv
// Combinational write classifier: (A0, data, current state) -> one-hot write class.
module pic_cmd_decode
    import pic_pkg::*;
(
    input  logic       a0_i,
    input  logic [7:0] d_in_i,
    input  logic [2:0] state_i,
    output wr_class_t  cls_o
);

    logic unused_d;
    assign unused_d = &{1'b0, d_in_i[7:5], d_in_i[2:0]};

    always_comb begin
        cls_o = '0;
        if (!a0_i && d_in_i[ICW1_FLAG]) begin
            cls_o.icw1 = 1'b1;
        end else if (state_i == ST_READY) begin
            if (a0_i)                    cls_o.ocw1 = 1'b1;
            else if (d_in_i[OCW3_FLAG])  cls_o.ocw3 = 1'b1;
            else                         cls_o.ocw2 = 1'b1;
        end else if (a0_i && (state_i == ST_WAIT_ICW2 || state_i == ST_WAIT_ICW3 ||
                              state_i == ST_WAIT_ICW4)) begin
            cls_o.icwn = 1'b1;
        end else begin
            cls_o.ignore = 1'b1;
        end
    end

endmodule

// File: rtl/pic_cmd_sequencer.sv
// 8259-style PIC command sequencer: ICW1..ICW4 init sequence and OCW1..OCW3 registers.
// Build option: PIC_OCW3_RR_HOLD_EN selects 8259 RR/ESMM hold semantics on OCW3 writes.
module pic_cmd_sequencer
    import pic_pkg::*;
#(
    parameter logic [7:0] OCW3_INIT    = OCW3_INIT_DEF,
    parameter logic [7:0] ICW4_DEFAULT = 8'h00
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       WR,
    input  logic       A0,
    input  logic [7:0] D_IN,
    output logic [7:0] ICW1,
    output logic [7:0] ICW2,
    output logic [7:0] ICW3,
    output logic [7:0] ICW4,
    output logic [7:0] OCW1,
    output logic [7:0] OCW2,
    output logic [7:0] OCW3,
    output logic       OCW2_STB,
    output logic       INIT_DONE,
    output logic       WR_IGNORED,
    output logic [2:0] INIT_STATE
);

    logic [2:0] state_q, state_d;
    logic [7:0] icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;
    logic [7:0] ocw1_q, ocw1_d, ocw2_q, ocw2_d, ocw3_q, ocw3_d;
    logic       stb_q, stb_d, ign_q, ign_d;
    wr_class_t  cls;

    pic_cmd_decode u_decode (
        .a0_i    (A0),
        .d_in_i  (D_IN),
        .state_i (state_q),
        .cls_o   (cls)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_UNINIT;
            icw1_q  <= '0;
            icw2_q  <= '0;
            icw3_q  <= '0;
            icw4_q  <= '0;
            ocw1_q  <= '0;
            ocw2_q  <= '0;
            ocw3_q  <= OCW3_INIT;
            stb_q   <= 1'b0;
            ign_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            icw1_q  <= icw1_d;
            icw2_q  <= icw2_d;
            icw3_q  <= icw3_d;
            icw4_q  <= icw4_d;
            ocw1_q  <= ocw1_d;
            ocw2_q  <= ocw2_d;
            ocw3_q  <= ocw3_d;
            stb_q   <= stb_d;
            ign_q   <= ign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        icw1_d  = icw1_q;
        icw2_d  = icw2_q;
        icw3_d  = icw3_q;
        icw4_d  = icw4_q;
        ocw1_d  = ocw1_q;
        ocw2_d  = ocw2_q;
        ocw3_d  = ocw3_q;
        stb_d   = 1'b0;
        ign_d   = 1'b0;
        if (WR) begin
            if (cls.icw1) begin
                icw1_d  = D_IN;
                icw2_d  = '0;
                icw3_d  = '0;
                icw4_d  = '0;
                ocw1_d  = '0;
                ocw3_d  = OCW3_INIT;
                state_d = ST_WAIT_ICW2;
            end else if (cls.icwn) begin
                // ICW3/ICW4 are skipped according to ICW1.SNGL and ICW1.IC4.
                case (state_q)
                    ST_WAIT_ICW2: begin
                        icw2_d = D_IN;
                        if (!icw1_q[SNGL])     state_d = ST_WAIT_ICW3;
                        else if (icw1_q[IC4])  state_d = ST_WAIT_ICW4;
                        else begin
                            state_d = ST_READY;
                            icw4_d  = ICW4_DEFAULT;
                        end
                    end
                    ST_WAIT_ICW3: begin
                        icw3_d = D_IN;
                        if (icw1_q[IC4]) state_d = ST_WAIT_ICW4;
                        else begin
                            state_d = ST_READY;
                            icw4_d  = ICW4_DEFAULT;
                        end
                    end
                    ST_WAIT_ICW4: begin
                        icw4_d  = D_IN;
                        state_d = ST_READY;
                    end
                    default: ;
                endcase
            end else if (cls.ocw1) begin
                ocw1_d = D_IN;
            end else if (cls.ocw2) begin
                ocw2_d = D_IN;
                stb_d  = 1'b1;
            end else if (cls.ocw3) begin
`ifdef PIC_OCW3_RR_HOLD_EN
                ocw3_d = D_IN;
                if (!D_IN[RR])   ocw3_d[RR:RIS] = ocw3_q[RR:RIS];
                if (!D_IN[ESMM]) ocw3_d[SMM]    = ocw3_q[SMM];
`else
                ocw3_d = D_IN;
`endif
            end else begin
                ign_d = 1'b1;
            end
        end
    end

    always_comb begin
        ICW1       = icw1_q;
        ICW2       = icw2_q;
        ICW3       = icw3_q;
        ICW4       = icw4_q;
        OCW1       = ocw1_q;
        OCW2       = ocw2_q;
        OCW3       = ocw3_q;
        OCW2_STB   = stb_q;
        WR_IGNORED = ign_q;
        INIT_DONE  = (state_q == ST_READY);
        INIT_STATE = state_q;
    end

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Self-checking bench for pic_cmd_sequencer: directed init/operational scenarios plus random writes.
module tb_pic_cmd_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1, WR = 1'b0, A0 = 1'b0;
    logic [7:0] D_IN = 8'h00;
    logic [7:0] ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3;
    logic       OCW2_STB, INIT_DONE, WR_IGNORED;
    logic [2:0] INIT_STATE;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    pic_cmd_sequencer dut (
        .CLK(CLK), .RST(RST), .WR(WR), .A0(A0), .D_IN(D_IN),
        .ICW1(ICW1), .ICW2(ICW2), .ICW3(ICW3), .ICW4(ICW4),
        .OCW1(OCW1), .OCW2(OCW2), .OCW3(OCW3),
        .OCW2_STB(OCW2_STB), .INIT_DONE(INIT_DONE),
        .WR_IGNORED(WR_IGNORED), .INIT_STATE(INIT_STATE)
    );

    always #5 CLK = ~CLK;

    // Model: icw[1..4], ocw[1..3]; pending holds the ICW numbers still owed in the init sequence.
    logic [7:0] m_icw [1:4];
    logic [7:0] m_ocw [1:3];
    bit         m_started, m_stb, m_ign;
    int         pending[$];

    function automatic int m_state();
        if (!m_started)          return 0;
        if (pending.size() == 0) return 4;
        return pending[0] - 1;
    endfunction

    task automatic model_step(input bit r, input bit w, input bit a0, input logic [7:0] d);
        m_stb = 1'b0;
        m_ign = 1'b0;
        if (r) begin
            for (int i = 1; i <= 4; i++) m_icw[i] = 8'h00;
            m_ocw[1] = 8'h00; m_ocw[2] = 8'h00; m_ocw[3] = 8'h0A;
            m_started = 1'b0;
            pending.delete();
        end else if (w) begin
            if (!a0 && d[4]) begin
                m_icw[1] = d;
                for (int i = 2; i <= 4; i++) m_icw[i] = 8'h00;
                m_ocw[1] = 8'h00; m_ocw[3] = 8'h0A;
                m_started = 1'b1;
                pending.delete();
                pending.push_back(2);
                if (!d[1]) pending.push_back(3);
                if (d[0])  pending.push_back(4);
            end else if (m_state() == 4) begin
                if (a0) m_ocw[1] = d;
                else if (!d[3]) begin m_ocw[2] = d; m_stb = 1'b1; end
                else begin
`ifdef PIC_OCW3_RR_HOLD_EN
                    logic [7:0] n;
                    n = d;
                    if (!d[1]) n[1:0] = m_ocw[3][1:0];
                    if (!d[6]) n[5]   = m_ocw[3][5];
                    m_ocw[3] = n;
`else
                    m_ocw[3] = d;
`endif
                end
            end else if (!m_started || !a0) begin
                m_ign = 1'b1;
            end else begin
                m_icw[pending.pop_front()] = d;
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit w, input bit a0, input logic [7:0] d);
        RST = r; WR = w; A0 = a0; D_IN = d;
        @(posedge CLK);
        #1;
        model_step(r, w, a0, d);
        RST = 1'b0; WR = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("icw1", ICW1, m_icw[1]);
            chk("icw2", ICW2, m_icw[2]);
            chk("icw3", ICW3, m_icw[3]);
            chk("icw4", ICW4, m_icw[4]);
            chk("ocw1", OCW1, m_ocw[1]);
            chk("ocw2", OCW2, m_ocw[2]);
            chk("ocw3", OCW3, m_ocw[3]);
            chk("ocw2_stb", {7'd0, OCW2_STB}, {7'd0, m_stb});
            chk("wr_ignored", {7'd0, WR_IGNORED}, {7'd0, m_ign});
            chk("init_done", {7'd0, INIT_DONE}, {7'd0, m_state() == 4});
            chk("init_state", {5'd0, INIT_STATE}, 8'(m_state()));
        end
    end

    initial begin
        logic [7:0] ocw3_exp;
        // Reset with a competing ICW1 write: reset must win.
        cyc(1, 1, 0, 8'h1A);
        chk_en = 1'b1;
        cyc(1, 1, 0, 8'h1A);
        chk("rst_icw1", ICW1, 8'h00);
        chk("rst_ocw3", OCW3, 8'h0A);
        chk("rst_state", {5'd0, INIT_STATE}, 8'd0);
        chk("rst_done", {7'd0, INIT_DONE}, 8'd0);

        cyc(0, 1, 1, 8'hFF);
        chk("ign_uninit", {7'd0, WR_IGNORED}, 8'd1);
        chk("ign_uninit_ocw1", OCW1, 8'h00);
        cyc(0, 0, 0, 8'h00);
        chk("ign_pulse_end", {7'd0, WR_IGNORED}, 8'd0);

        // Single mode, no ICW4.
        cyc(0, 1, 0, 8'h1A);
        chk("single_state1", {5'd0, INIT_STATE}, 8'd1);
        chk("single_done0", {7'd0, INIT_DONE}, 8'd0);
        cyc(0, 1, 1, 8'hA8);
        chk("single_icw1", ICW1, 8'h1A);
        chk("single_icw2", ICW2, 8'hA8);
        chk("single_icw4", ICW4, 8'h00);
        chk("single_done", {7'd0, INIT_DONE}, 8'd1);

        // Cascade with ICW4.
        cyc(0, 1, 0, 8'h11); chk("casc_s1", {5'd0, INIT_STATE}, 8'd1);
        cyc(0, 1, 1, 8'hA8); chk("casc_s2", {5'd0, INIT_STATE}, 8'd2);
        cyc(0, 1, 1, 8'h04); chk("casc_s3", {5'd0, INIT_STATE}, 8'd3);
        chk("casc_done_early", {7'd0, INIT_DONE}, 8'd0);
        cyc(0, 1, 1, 8'h02); chk("casc_s4", {5'd0, INIT_STATE}, 8'd4);
        chk("casc_icw3", ICW3, 8'h04);
        chk("casc_icw4", ICW4, 8'h02);
        chk("casc_done", {7'd0, INIT_DONE}, 8'd1);

        // Operational writes.
        cyc(0, 1, 1, 8'h07); chk("op_ocw1", OCW1, 8'h07);
        cyc(0, 1, 0, 8'h20); chk("op_ocw2", OCW2, 8'h20);
        chk("op_stb_hi", {7'd0, OCW2_STB}, 8'd1);
        cyc(0, 0, 0, 8'h00); chk("op_stb_lo", {7'd0, OCW2_STB}, 8'd0);
        cyc(0, 1, 0, 8'h08);
`ifdef PIC_OCW3_RR_HOLD_EN
        ocw3_exp = 8'h0A;
`else
        ocw3_exp = 8'h08;
`endif
        chk("op_ocw3", OCW3, ocw3_exp);

        // Re-init mid-sequence.
        cyc(0, 1, 0, 8'h11);
        cyc(0, 1, 1, 8'hA8);
        cyc(0, 1, 0, 8'h1B);
        chk("reinit_state", {5'd0, INIT_STATE}, 8'd1);
        chk("reinit_ocw1", OCW1, 8'h00);
        chk("reinit_icw2", ICW2, 8'h00);
        cyc(0, 1, 1, 8'h48); chk("reinit_s3", {5'd0, INIT_STATE}, 8'd3);
        cyc(0, 1, 1, 8'h03); chk("reinit_ready", {5'd0, INIT_STATE}, 8'd4);
        chk("reinit_icw4", ICW4, 8'h03);

        // Discarded A0=0 write while waiting for ICW2.
        cyc(0, 1, 0, 8'h1B);
        cyc(0, 1, 0, 8'h20);
        chk("ign_wait_pulse", {7'd0, WR_IGNORED}, 8'd1);
        chk("ign_wait_ocw2", OCW2, 8'h20);
        chk("ign_wait_state", {5'd0, INIT_STATE}, 8'd1);

        // Random traffic; ICW1 is made rarer so sequences reach READY often.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            bit a0;
            d  = 8'($urandom);
            a0 = 1'($urandom);
            if (!a0 && $urandom_range(0, 3) != 0) d[4] = 1'b0;
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, a0, d);
        end

        @(negedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
